// File: rtl/add_n.sv
// rtl/add_n.sv - registered N-bit ripple-carry adder with carry-out, zero and signed-overflow flags
// Build option ADD_OVF_EN: when defined ovf is the registered overflow flag, otherwise ovf is tied to 0.
module add_n #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         zero,
  output logic         ovf,
  output logic         out_valid
);

  logic [N:0]   carry;
  logic [N-1:0] sum;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
  end

  logic [N-1:0] s_d, s_q;
  logic         c_out_d, c_out_q;
  logic         zero_d, zero_q;
  logic         out_valid_d, out_valid_q;

  // Result registers hold their value whenever no new operands arrive.
  always_comb begin
    s_d         = s_q;
    c_out_d     = c_out_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum;
      c_out_d     = carry[N];
      zero_d      = (sum == '0);
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_q         <= '0;
      c_out_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      c_out_q     <= c_out_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign c_out     = c_out_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

`ifdef ADD_OVF_EN
  logic ovf_d, ovf_q;

  // Carry into and out of the sign bit differ exactly when the signed sum overflows.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = carry[N] ^ carry[N-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_add_n.sv
// tb/tb_add_n.sv - scoreboard bench for add_n at N=1, 8 and 16
module tb_add_n;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        v8, c8i, co8, z8, o8, ov8;
  logic [7:0]  x8, y8, s8;
  logic        v1, c1i, co1, z1, o1, ov1;
  logic [0:0]  x1, y1, s1;
  logic        v16, c16i, co16, z16, o16, ov16;
  logic [15:0] x16, y16, s16;

  add_n #(.N(8)) u_add8 (
    .clock(clock), .reset(reset), .in_valid(v8), .x(x8), .y(y8), .c_in(c8i),
    .s(s8), .c_out(co8), .zero(z8), .ovf(o8), .out_valid(ov8)
  );
  add_n #(.N(1)) u_add1 (
    .clock(clock), .reset(reset), .in_valid(v1), .x(x1), .y(y1), .c_in(c1i),
    .s(s1), .c_out(co1), .zero(z1), .ovf(o1), .out_valid(ov1)
  );
  add_n #(.N(16)) u_add16 (
    .clock(clock), .reset(reset), .in_valid(v16), .x(x16), .y(y16), .c_in(c16i),
    .s(s16), .c_out(co16), .zero(z16), .ovf(o16), .out_valid(ov16)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Packed record: [19]=out_valid, [18:3]=s (zero-extended), [2]=c_out, [1]=zero, [0]=ovf
  logic [19:0] q8[$];
  logic [19:0] q1[$];
  logic [19:0] q16[$];
  logic [19:0] last8, last1, last16;

  wire [19:0] obs8  = {ov8, 8'h00, s8, co8, z8, o8};
  wire [19:0] obs1  = {ov1, 15'h0000, s1, co1, z1, o1};
  wire [19:0] obs16 = {ov16, s16, co16, z16, o16};

  function automatic logic [19:0] model(input int n, input logic [15:0] a,
                                        input logic [15:0] b, input logic c);
    logic [16:0] full;
    logic [15:0] sm;
    logic        co, ov;
    int          sa, sb, ss;
    full = {1'b0, a} + {1'b0, b} + {16'h0000, c};
    sm   = full[15:0] & 16'((17'h1 << n) - 1);
    co   = full[n];
    sa   = a[n-1] ? int'(a) - (1 << n) : int'(a);
    sb   = b[n-1] ? int'(b) - (1 << n) : int'(b);
    ss   = sa + sb + int'(c);
`ifdef ADD_OVF_EN
    ov = (ss > (1 << (n - 1)) - 1) || (ss < -(1 << (n - 1)));
`else
    ov = 1'b0;
`endif
    return {1'b1, sm, co, (sm == 16'h0000), ov};
  endfunction

  task automatic next8(output logic [19:0] e);
    if (q8.size() > 0) begin
      last8 = q8.pop_front();
      e = last8;
    end else begin
      e = {1'b0, last8[18:0]};
    end
  endtask

  task automatic next1(output logic [19:0] e);
    if (q1.size() > 0) begin
      last1 = q1.pop_front();
      e = last1;
    end else begin
      e = {1'b0, last1[18:0]};
    end
  endtask

  task automatic next16(output logic [19:0] e);
    if (q16.size() > 0) begin
      last16 = q16.pop_front();
      e = last16;
    end else begin
      e = {1'b0, last16[18:0]};
    end
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clock);
    v8 = v; x8 = a; y8 = b; c8i = c;
    if (v && !reset) q8.push_back(model(8, {8'h00, a}, {8'h00, b}, c));
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    v8 = 1'b1; x8 = 8'hFF; y8 = 8'h01; c8i = 1'b0;
    v1 = 1'b1; x1 = 1'b1; y1 = 1'b1; c1i = 1'b1;
    v16 = 1'b1; x16 = 16'hFFFF; y16 = 16'h0001; c16i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (obs8 !== 20'h0) begin
        n_err++;
        $display("FAIL reset8 cycle %0d: got %h expected %h", k, obs8, 20'h0);
      end
      n_cmp++;
      if (obs1 !== 20'h0) begin
        n_err++;
        $display("FAIL reset1 cycle %0d: got %h expected %h", k, obs1, 20'h0);
      end
      n_cmp++;
      if (obs16 !== 20'h0) begin
        n_err++;
        $display("FAIL reset16 cycle %0d: got %h expected %h", k, obs16, 20'h0);
      end
    end
    q8.delete(); q1.delete(); q16.delete();
    last8 = '0; last1 = '0; last16 = '0;
    @(negedge clock);
    reset = 1'b0;
    v8 = 1'b0; v1 = 1'b0; v16 = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs8 !== 20'h0) begin
      n_err++;
      $display("FAIL reset_release: got %h expected %h", obs8, 20'h0);
    end
  endtask

  task automatic test_subtract;
    logic [7:0]  ta[3] = '{8'h05, 8'h03, 8'h00};
    logic [7:0]  tb[3] = '{8'hFC, 8'hFA, 8'hFF};
    logic [19:0] e;
    for (int k = 0; k < 3; k++) begin
      drive8(1'b1, ta[k], tb[k], 1'b1);
      next8(e);
      n_cmp++;
      if (obs8 !== e) begin
        n_err++;
        $display("FAIL subtract %0d (%h+%h+1): got %h expected %h", k, ta[k], tb[k], obs8, e);
      end
    end
  endtask

  task automatic test_wrap_flags;
    logic [7:0]  ta[4] = '{8'hFF, 8'h7F, 8'h80, 8'hC0};
    logic [7:0]  tb[4] = '{8'h01, 8'h01, 8'h80, 8'h40};
    logic [19:0] e;
    for (int k = 0; k < 4; k++) begin
      drive8(1'b1, ta[k], tb[k], 1'b0);
      next8(e);
      n_cmp++;
      if (obs8 !== e) begin
        n_err++;
        $display("FAIL wrap_flags %0d (%h+%h): got %h expected %h", k, ta[k], tb[k], obs8, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] e;
    logic [7:0]  a, b;
    for (int k = 0; k < 5; k++) begin
      a = 8'(8'h31 * (k + 1));
      b = 8'(8'h4D + 8'(k * 17));
      drive8(k < 3, a, b, k[0]);
      next8(e);
      n_cmp++;
      if (obs8 !== e) begin
        n_err++;
        $display("FAIL back_to_back cycle %0d: got %h expected %h", k, obs8, e);
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [19:0] e;
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    next8(e);
    n_cmp++;
    if (obs8 !== e) begin
      n_err++;
      $display("FAIL midstream_pre: got %h expected %h", obs8, e);
    end
    @(negedge clock);
    reset = 1'b1;
    v8 = 1'b1; x8 = 8'h7F; y8 = 8'h7F; c8i = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (obs8 !== 20'h0) begin
      n_err++;
      $display("FAIL midstream_reset: got %h expected %h", obs8, 20'h0);
    end
    last8 = '0;
    @(negedge clock);
    reset = 1'b0;
    v8 = 1'b0;
    drive8(1'b1, 8'h7F, 8'h7F, 1'b1);
    next8(e);
    n_cmp++;
    if (obs8 !== e) begin
      n_err++;
      $display("FAIL midstream_post: got %h expected %h", obs8, e);
    end
  endtask

  task automatic test_width_sweep;
    logic [19:0] e;
    @(negedge clock);
    v1 = 1'b1; x1 = 1'b1; y1 = 1'b1; c1i = 1'b1;
    q1.push_back(model(1, 16'h0001, 16'h0001, 1'b1));
    @(posedge clock);
    #1;
    n_cmp++;
    if ({ov1, co1, s1} !== 3'b111) begin
      n_err++;
      $display("FAIL n1_all_ones: got %b expected %b", {ov1, co1, s1}, 3'b111);
    end
    next1(e);
    n_cmp++;
    if (obs1 !== e) begin
      n_err++;
      $display("FAIL n1_all_ones_model: got %h expected %h", obs1, e);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      v8 = ($urandom_range(3) != 0); x8 = 8'($urandom); y8 = 8'($urandom); c8i = 1'($urandom);
      v1 = ($urandom_range(3) != 0); x1 = 1'($urandom); y1 = 1'($urandom); c1i = 1'($urandom);
      v16 = ($urandom_range(3) != 0); x16 = 16'($urandom); y16 = 16'($urandom); c16i = 1'($urandom);
      if (v8) q8.push_back(model(8, {8'h00, x8}, {8'h00, y8}, c8i));
      if (v1) q1.push_back(model(1, {15'h0000, x1}, {15'h0000, y1}, c1i));
      if (v16) q16.push_back(model(16, x16, y16, c16i));
      @(posedge clock);
      #1;
      next8(e);
      n_cmp++;
      if (obs8 !== e) begin
        n_err++;
        $display("FAIL sweep8 cycle %0d: got %h expected %h", k, obs8, e);
      end
      next1(e);
      n_cmp++;
      if (obs1 !== e) begin
        n_err++;
        $display("FAIL sweep1 cycle %0d: got %h expected %h", k, obs1, e);
      end
      next16(e);
      n_cmp++;
      if (obs16 !== e) begin
        n_err++;
        $display("FAIL sweep16 cycle %0d: got %h expected %h", k, obs16, e);
      end
    end
    @(negedge clock);
    v8 = 1'b0; v1 = 1'b0; v16 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    v8 = 1'b0; x8 = '0; y8 = '0; c8i = 1'b0;
    v1 = 1'b0; x1 = '0; y1 = '0; c1i = 1'b0;
    v16 = 1'b0; x16 = '0; y16 = '0; c16i = 1'b0;
    last8 = '0; last1 = '0; last16 = '0;
    test_reset();
    test_subtract();
    test_wrap_flags();
    test_back_to_back();
    test_reset_midstream();
    test_width_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
